// File: rtl/accumulator_deskew_if.sv
// Bus bundle for accumulator_deskew: staggered column beats in, aligned rows out, status/error flags.
interface accumulator_deskew_if #(
    parameter int unsigned N_COLS     = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned ROW_W = N_COLS * DATA_W;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [N_COLS-1:0] col_valid;
    logic [ROW_W-1:0]  col_data;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_data;
    logic [LVL_W-1:0]  fifo_level;
    logic [15:0]       row_count;
    logic              err_clr;
    logic              err_skew;
    logic              err_ovf;

    modport master (
        output col_valid, col_data, out_ready, err_clr,
        input  out_valid, out_data, fifo_level, row_count, err_skew, err_ovf
    );

    modport slave (
        input  col_valid, col_data, out_ready, err_clr,
        output out_valid, out_data, fifo_level, row_count, err_skew, err_ovf
    );
endinterface

// File: rtl/accumulator_deskew.sv
// Deskews staggered accumulator columns into whole rows and queues them in a small valid/ready FIFO.
// Optional skew-event detection (err_skew) is enabled by defining ACC_DESKEW_SKEW_CHECK_EN.
module accumulator_deskew #(
    parameter int unsigned N_COLS     = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    accumulator_deskew_if.slave   bus
);
    localparam int unsigned ROW_W = N_COLS * DATA_W;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [N_COLS-1:0] aligned_v;
    logic [DATA_W-1:0] aligned_d [N_COLS];
    logic [ROW_W-1:0]  aligned_row;

    // Column i is delayed by N_COLS-1-i stages so every column of a row meets at the alignment point.
    for (genvar i = 0; i < N_COLS; i++) begin : g_col
        localparam int unsigned D = N_COLS - 1 - i;
        if (D == 0) begin : g_pass
            assign aligned_v[i] = bus.col_valid[i];
            assign aligned_d[i] = bus.col_data[i*DATA_W +: DATA_W];
        end else begin : g_dly
            logic              v_q [D];
            logic [DATA_W-1:0] d_q [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) begin
                        v_q[k] <= 1'b0;
                        d_q[k] <= '0;
                    end
                end else begin
                    v_q[0] <= bus.col_valid[i];
                    d_q[0] <= bus.col_data[i*DATA_W +: DATA_W];
                    for (int k = 1; k < D; k++) begin
                        v_q[k] <= v_q[k-1];
                        d_q[k] <= d_q[k-1];
                    end
                end
            end

            assign aligned_v[i] = v_q[D-1];
            assign aligned_d[i] = d_q[D-1];
        end
    end

    always_comb begin
        aligned_row = '0;
        for (int i = 0; i < N_COLS; i++) begin
            aligned_row[i*DATA_W +: DATA_W] = aligned_d[i];
        end
    end

    logic [ROW_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic             valid_q;
    logic [15:0]      row_cnt;
    logic             ovf_q;

    logic row_full;
    logic fifo_full;
    logic pop;
    logic push;
    logic ovf_evt;

    assign row_full  = &aligned_v;
    assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
    assign pop       = valid_q & bus.out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign push      = row_full & (~fifo_full | pop);
    assign ovf_evt   = row_full & fifo_full & ~pop;

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem[k] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            valid_q <= 1'b0;
            row_cnt <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= aligned_row;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                row_cnt <= row_cnt + 16'd1;
            end
            level   <= level_next;
            valid_q <= (level_next != '0);
            ovf_q   <= ovf_evt | (ovf_q & ~bus.err_clr);
        end
    end

`ifdef ACC_DESKEW_SKEW_CHECK_EN
    logic skew_q;
    logic partial;

    assign partial = (|aligned_v) & ~row_full;

    // Set has priority over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_q <= 1'b0;
        end else begin
            skew_q <= partial | (skew_q & ~bus.err_clr);
        end
    end

    assign bus.err_skew = skew_q;
`else
    assign bus.err_skew = 1'b0;
`endif

    assign bus.out_valid  = valid_q;
    assign bus.out_data   = mem[rd_ptr];
    assign bus.fifo_level = level;
    assign bus.row_count  = row_cnt;
    assign bus.err_ovf    = ovf_q;

endmodule

// File: tb/tb_accumulator_deskew.sv
// Self-checking bench for accumulator_deskew: directed table, corner sequences, and random traffic vs a queue model.
module tb_accumulator_deskew;
    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RW    = N * DW;
    localparam int unsigned RING  = 16;
`ifdef ACC_DESKEW_SKEW_CHECK_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    accumulator_deskew_if #(.N_COLS(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    accumulator_deskew #(.N_COLS(N), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    // Stimulus ring: beats scheduled by launch(), presented by step_ring().
    logic          in_v [RING][N];
    logic [DW-1:0] in_d [RING][N];
    // Model: beats indexed by the cycle in which they reach the alignment point.
    logic          sv   [RING][N];
    logic [DW-1:0] sd   [RING][N];
    logic [RW-1:0] mq [$];
    logic [15:0]   m_rc;
    logic          m_ovf;
    logic          m_skew;

    typedef struct {
        logic [N-1:0]  cv;
        logic [RW-1:0] cd;
        logic          rdy;
        logic          ev;
        logic [RW-1:0] ed;
        logic [2:0]    el;
        logic [15:0]   erc;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic clear_all();
        for (int r = 0; r < RING; r++) begin
            for (int i = 0; i < N; i++) begin
                in_v[r][i] = 1'b0;
                in_d[r][i] = '0;
                sv[r][i]   = 1'b0;
                sd[r][i]   = '0;
            end
        end
        mq.delete();
        m_rc   = '0;
        m_ovf  = 1'b0;
        m_skew = 1'b0;
        cyc    = 0;
    endtask

    task automatic model_cycle(input logic [N-1:0] cv, input logic [RW-1:0] cd,
                               input logic rdy, input logic clr);
        logic [N-1:0]  av;
        logic [RW-1:0] row;
        int            a;
        bit            pop, full, ovf_ev, part;
        for (int i = 0; i < N; i++) begin
            if (cv[i]) begin
                sv[(cyc + N - 1 - i) % RING][i] = 1'b1;
                sd[(cyc + N - 1 - i) % RING][i] = cd[i*DW +: DW];
            end
        end
        a   = int'(cyc % RING);
        row = '0;
        for (int i = 0; i < N; i++) begin
            av[i]          = sv[a][i];
            row[i*DW +: DW] = sd[a][i];
            sv[a][i]       = 1'b0;
        end
        full = (mq.size() == DEPTH);
        pop  = (mq.size() != 0) && rdy;
        if (pop) begin
            void'(mq.pop_front());
            m_rc = m_rc + 16'd1;
        end
        ovf_ev = 1'b0;
        if (&av) begin
            if (!full || pop) mq.push_back(row);
            else ovf_ev = 1'b1;
        end
        part   = (av != '0) && !(&av);
        m_ovf  = ovf_ev | (m_ovf & !clr);
        m_skew = SKEW_EN & (part | (m_skew & !clr));
    endtask

    task automatic compare_outputs();
        chk("out_valid", RW'(bus.out_valid), RW'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", bus.out_data, mq[0]);
        chk("fifo_level", RW'(bus.fifo_level), RW'(mq.size()));
        chk("row_count", RW'(bus.row_count), RW'(m_rc));
        chk("err_ovf", RW'(bus.err_ovf), RW'(m_ovf));
        chk("err_skew", RW'(bus.err_skew), RW'(m_skew));
    endtask

    task automatic step(input logic [N-1:0] cv, input logic [RW-1:0] cd,
                        input logic rdy, input logic clr);
        bus.col_valid = cv;
        bus.col_data  = cd;
        bus.out_ready = rdy;
        bus.err_clr   = clr;
        model_cycle(cv, cd, rdy, clr);
        @(posedge clk);
        #1;
        cyc++;
        compare_outputs();
    endtask

    task automatic step_ring(input logic rdy, input logic clr);
        logic [N-1:0]  cv;
        logic [RW-1:0] cd;
        int            r;
        r  = int'(cyc % RING);
        cd = '0;
        for (int i = 0; i < N; i++) begin
            cv[i]          = in_v[r][i];
            cd[i*DW +: DW] = in_v[r][i] ? in_d[r][i] : '0;
            in_v[r][i]     = 1'b0;
        end
        step(cv, cd, rdy, clr);
    endtask

    task automatic launch(input logic [RW-1:0] row, input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                in_v[(cyc + i) % RING][i] = 1'b1;
                in_d[(cyc + i) % RING][i] = row[i*DW +: DW];
            end
        end
    endtask

    task automatic do_reset();
        bus.col_valid = '0;
        bus.col_data  = '0;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        rst_n = 1'b0;
        #1;
        clear_all();
        chk("rst_out_valid", RW'(bus.out_valid), RW'(0));
        chk("rst_out_data", bus.out_data, RW'(0));
        chk("rst_fifo_level", RW'(bus.fifo_level), RW'(0));
        chk("rst_row_count", RW'(bus.row_count), RW'(0));
        chk("rst_err_ovf", RW'(bus.err_ovf), RW'(0));
        chk("rst_err_skew", RW'(bus.err_skew), RW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [RW-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int vcnt;
        logic [N-1:0] mask;

        tbl[0] = '{cv: 4'b0001, cd: {32'h0, 32'h0, 32'h0, 32'h11}, rdy: 1'b1,
                   ev: 1'b0, ed: '0, el: 3'd0, erc: 16'd0};
        tbl[1] = '{cv: 4'b0010, cd: {32'h0, 32'h0, 32'h22, 32'h0}, rdy: 1'b1,
                   ev: 1'b0, ed: '0, el: 3'd0, erc: 16'd0};
        tbl[2] = '{cv: 4'b0100, cd: {32'h0, 32'h33, 32'h0, 32'h0}, rdy: 1'b1,
                   ev: 1'b0, ed: '0, el: 3'd0, erc: 16'd0};
        tbl[3] = '{cv: 4'b1000, cd: {32'h44, 32'h0, 32'h0, 32'h0}, rdy: 1'b1,
                   ev: 1'b1, ed: {32'h44, 32'h33, 32'h22, 32'h11}, el: 3'd1, erc: 16'd0};
        tbl[4] = '{cv: 4'b0000, cd: '0, rdy: 1'b1,
                   ev: 1'b0, ed: '0, el: 3'd0, erc: 16'd1};
        tbl[5] = '{cv: 4'b0000, cd: '0, rdy: 1'b1,
                   ev: 1'b0, ed: '0, el: 3'd0, erc: 16'd1};

        #2;
        do_reset();

        // Single staggered row from the table.
        for (int k = 0; k < 6; k++) begin
            step(tbl[k].cv, tbl[k].cd, tbl[k].rdy, 1'b0);
            chk("tbl_valid", RW'(bus.out_valid), RW'(tbl[k].ev));
            if (tbl[k].ev) chk("tbl_data", bus.out_data, tbl[k].ed);
            chk("tbl_level", RW'(bus.fifo_level), RW'(tbl[k].el));
            chk("tbl_row_count", RW'(bus.row_count), RW'(tbl[k].erc));
            chk("tbl_err_ovf", RW'(bus.err_ovf), RW'(0));
            chk("tbl_err_skew", RW'(bus.err_skew), RW'(0));
        end

        // Back-to-back streaming of 8 rows.
        do_reset();
        vcnt = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) launch(rand_row(), 4'hF);
            step_ring(1'b1, 1'b0);
            if (bus.out_valid) vcnt++;
            chk("stream_level_le1", RW'(bus.fifo_level <= 1), RW'(1));
        end
        chk("stream_valid_cycles", RW'(vcnt), RW'(8));
        chk("stream_row_count", RW'(bus.row_count), RW'(8));

        // Full FIFO with a simultaneous pop accepts the incoming row.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 5) launch(rand_row(), 4'hF);
            step_ring(c == 7, 1'b0);
        end
        chk("fullpop_level", RW'(bus.fifo_level), RW'(4));
        chk("fullpop_ovf", RW'(bus.err_ovf), RW'(0));
        chk("fullpop_row_count", RW'(bus.row_count), RW'(1));

        // Backpressure: 6 rows into a 4-deep FIFO.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 6) launch(rand_row(), 4'hF);
            step_ring(1'b0, 1'b0);
        end
        chk("ovf_level", RW'(bus.fifo_level), RW'(4));
        chk("ovf_flag", RW'(bus.err_ovf), RW'(1));
        for (int c = 0; c < 6; c++) step_ring(1'b1, 1'b0);
        chk("ovf_row_count", RW'(bus.row_count), RW'(4));
        chk("ovf_drained", RW'(bus.fifo_level), RW'(0));
        step_ring(1'b1, 1'b1);
        chk("ovf_cleared", RW'(bus.err_ovf), RW'(0));

        // Skew: column 2 missing, then clear, then set-wins-over-clear.
        do_reset();
        launch(rand_row(), 4'b1011);
        for (int c = 0; c < 4; c++) step_ring(1'b1, 1'b0);
        chk("skew_set", RW'(bus.err_skew), RW'(SKEW_EN));
        chk("skew_dropped", RW'(bus.fifo_level), RW'(0));
        step_ring(1'b1, 1'b1);
        chk("skew_clr", RW'(bus.err_skew), RW'(0));
        launch(rand_row(), 4'b0111);
        for (int c = 0; c < 3; c++) step_ring(1'b1, 1'b0);
        step_ring(1'b1, 1'b1);
        chk("skew_set_wins", RW'(bus.err_skew), RW'(SKEW_EN));
        step_ring(1'b1, 1'b1);

        // Mid-stream reset: 2 rows queued, 1 in flight.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c < 3) launch(rand_row(), 4'hF);
            step_ring(1'b0, 1'b0);
        end
        chk("midrst_queued", RW'(bus.fifo_level), RW'(2));
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step_ring(1'b0, 1'b0);
            chk("midrst_quiet", RW'(bus.out_valid), RW'(0));
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) != 0) begin
                mask = ($urandom_range(0, 4) == 0) ? N'($urandom) : 4'hF;
                launch(rand_row(), mask);
            end
            step_ring($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end
        for (int c = 0; c < 10; c++) step_ring(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
